// File: rtl/tv_pkg.sv
// Shared definitions for the test-vector sequencer: default widths and FSM state encoding.
package tv_pkg;

  localparam int STIM_W_DEF = 3;
  localparam int RESP_W_DEF = 1;
  localparam int AW_DEF     = 4;
  localparam int SETTLE_DEF = 1;
  localparam int ERR_W_DEF  = 8;

  // Sequencer states; encodings fixed so they read the same in waveforms across builds.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } tv_state_e;

endpackage

// File: rtl/tv_mem.sv
// Vector storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so loaded vectors survive a sequencer reset.
module tv_mem #(
  parameter int AW = 4,
  parameter int W  = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // Write one vector per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tv_sequencer.sv
// Test-vector sequencer: applies stored stimulus to a device, waits a fixed settle
// time, compares the device response with the stored expected value and keeps a
// saturating error count plus the index of the first failing vector.
module tv_sequencer
  import tv_pkg::*;
#(
  parameter int STIM_W = STIM_W_DEF,
  parameter int RESP_W = RESP_W_DEF,
  parameter int AW     = AW_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int ERR_W  = ERR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [AW-1:0]            load_addr,
  input  logic [STIM_W+RESP_W-1:0] load_data,
  input  logic [AW:0]              num_vec,
  input  logic                     start,
  output logic [STIM_W-1:0]        stim,
  input  logic [RESP_W-1:0]        resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_W-1:0]         err_count,
  output logic [AW:0]              vec_idx,
  output logic [AW:0]              first_fail
);

  localparam int DEPTH = 2**AW;
  localparam int VW    = STIM_W + RESP_W;
  // Counter holds SETTLE-1 at most, so clog2(SETTLE) bits suffice.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [AW:0]      DEPTH_V     = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  tv_state_e        state;
  logic [CNT_W-1:0] settle_cnt;
  logic [AW:0]      num_lat;
  logic [VW-1:0]    vec;
  logic [STIM_W-1:0] vec_stim;
  logic [RESP_W-1:0] vec_exp;
  logic             mismatch;
  logic [AW:0]      idx_next;
  logic             mem_we;

  // Saturating increment for the error counter: sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  // Requested vector counts beyond the memory depth run the whole memory once.
  function automatic logic [AW:0] clamp_num(input logic [AW:0] n);
    return (n > DEPTH_V) ? DEPTH_V : n;
  endfunction

  // Loading is locked out during a run so the vectors under test cannot change mid-run.
  assign mem_we = load_en & ~busy;

  tv_mem #(
    .AW (AW),
    .W  (VW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (vec_idx[AW-1:0]),
    .rdata (vec)
  );

  assign vec_stim = vec[VW-1:RESP_W];
  assign vec_exp  = vec[RESP_W-1:0];
  assign mismatch = (resp != vec_exp);
  assign idx_next = vec_idx + (AW+1)'(1);

  assign busy = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  // Run control: apply -> settle -> check per vector, until the latched count is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      stim       <= '0;
      err_count  <= '0;
      vec_idx    <= '0;
      first_fail <= '0;
      settle_cnt <= '0;
      num_lat    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count  <= '0;
            vec_idx    <= '0;
            first_fail <= '0;
            num_lat    <= clamp_num(num_vec);
            state      <= (num_vec == '0) ? S_DONE : S_APPLY;
          end
        end
        S_APPLY: begin
          stim <= vec_stim;
          if (SETTLE > 0) begin
            settle_cnt <= SETTLE_LOAD;
            state      <= S_WAIT;
          end else begin
            state <= S_CHECK;
          end
        end
        S_WAIT: begin
          if (settle_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= sat_inc(err_count);
            // A zero count means no earlier mismatch in this run.
            if (err_count == '0) begin
              first_fail <= vec_idx;
            end
          end
          vec_idx <= idx_next;
          state   <= (idx_next == num_lat) ? S_DONE : S_APPLY;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tv_sequencer.sv
// Bench for tv_sequencer: two instances (wide and 2-bit error counters) driven in
// lockstep, each feeding a 2:1 mux device model, checked against a vector-list model.
module tb_tv_sequencer;

  localparam int S = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_en;
  logic [3:0] load_addr;
  logic [3:0] load_data;
  logic [4:0] num_vec;
  logic       start;

  logic [2:0] stim_a, stim_b;
  logic       resp_a, resp_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] err_a;
  logic [1:0] err_b;
  logic [4:0] idx_a, idx_b, ff_a, ff_b;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] mem_m [16];
  logic [2:0] last_stim;

  always #5 clk = ~clk;

  // Device under test of the sequencer: a 2:1 mux with stim = {d0, d1, sel}.
  assign resp_a = stim_a[0] ? stim_a[1] : stim_a[2];
  assign resp_b = stim_b[0] ? stim_b[1] : stim_b[2];

  tv_sequencer #(.STIM_W(3), .RESP_W(1), .AW(4), .SETTLE(S), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start), .stim(stim_a),
    .resp(resp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .vec_idx(idx_a), .first_fail(ff_a)
  );

  tv_sequencer #(.STIM_W(3), .RESP_W(1), .AW(4), .SETTLE(S), .ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start), .stim(stim_b),
    .resp(resp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .vec_idx(idx_b), .first_fail(ff_b)
  );

  function automatic logic mux_ref(input logic [2:0] s);
    logic d0, d1, sel;
    d0 = s[2]; d1 = s[1]; sel = s[0];
    return sel ? d1 : d0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load_vec(input int a, input logic [2:0] sv, input logic ev);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 4'(a); load_data = {sv, ev};
    @(posedge clk); #1;
    load_en = 1'b0;
    mem_m[a] = {sv, ev};
  endtask

  task automatic load_correct();
    for (int i = 0; i < 8; i++) load_vec(i, 3'(i), mux_ref(3'(i)));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_stim"}, 32'(stim_a), 32'(0));
    chk({tag, "_busy"}, 32'(busy_a), 32'(0));
    chk({tag, "_done"}, 32'(done_a), 32'(0));
    chk({tag, "_pass"}, 32'(pass_a), 32'(0));
    chk({tag, "_err"},  32'(err_a),  32'(0));
    chk({tag, "_idx"},  32'(idx_a),  32'(0));
    chk({tag, "_ff"},   32'(ff_a),   32'(0));
    chk({tag, "_err_sat"}, 32'(err_b), 32'(0));
    chk({tag, "_stim_sat"}, 32'(stim_b), 32'(0));
    last_stim = 3'd0;
  endtask

  // Launch a run after a clock edge and follow it cycle by cycle. Optionally
  // pulses start and a load at address 2 while the run is busy.
  task automatic run(input int nreq, input bit disturb, input string tag);
    int n, errs, ff, dc, k;
    n = (nreq > 16) ? 16 : nreq;
    errs = 0; ff = 0;
    for (int v = 0; v < n; v++) begin
      if (mux_ref(mem_m[v][3:1]) != mem_m[v][0]) begin
        if (errs == 0) ff = v;
        errs++;
      end
    end
    dc = (n == 0) ? 1 : n * (S + 2) + 1;
    @(posedge clk); #1;
    start = 1'b1; num_vec = 5'(nreq);
    for (int t = 1; t <= dc + 1; t++) begin
      @(posedge clk); #1;
      if (t == 1) start = 1'b0;
      if (disturb && t == 3) begin
        start = 1'b1; num_vec = 5'd2;
        load_en = 1'b1; load_addr = 4'd2; load_data = {mem_m[2][3:1], ~mem_m[2][0]};
      end
      if (disturb && t == 4) begin
        start = 1'b0; load_en = 1'b0;
      end
      if (t >= 2 && n > 0) begin
        k = (t - 2) / (S + 2);
        if (k > n - 1) k = n - 1;
        last_stim = mem_m[k][3:1];
      end
      chk($sformatf("%s_busy_t%0d", tag, t), 32'(busy_a), 32'(t < dc));
      chk($sformatf("%s_done_t%0d", tag, t), 32'(done_a), 32'(t >= dc));
      chk($sformatf("%s_stim_t%0d", tag, t), 32'(stim_a), 32'(last_stim));
    end
    chk({tag, "_err"},      32'(err_a),  32'((errs > 255) ? 255 : errs));
    chk({tag, "_err_sat"},  32'(err_b),  32'((errs > 3) ? 3 : errs));
    chk({tag, "_ff"},       32'(ff_a),   32'((errs != 0) ? ff : 0));
    chk({tag, "_ff_sat"},   32'(ff_b),   32'((errs != 0) ? ff : 0));
    chk({tag, "_pass"},     32'(pass_a), 32'(errs == 0));
    chk({tag, "_pass_sat"}, 32'(pass_b), 32'(errs == 0));
    chk({tag, "_idx"},      32'(idx_a),  32'(n));
    chk({tag, "_stim_sat"}, 32'(stim_b), 32'(last_stim));
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    num_vec = '0; start = 1'b0; last_stim = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    reset = 1'b0;

    // All-correct mux table, 8 vectors.
    load_correct();
    run(8, 1'b0, "good8");

    // Vector 5 with inverted expectation.
    load_vec(5, 3'd5, ~mux_ref(3'd5));
    run(8, 1'b0, "bad5");

    // Empty run.
    run(0, 1'b0, "empty");

    // Abort in the settle phase of vector 3, then rerun from retained memory.
    load_vec(5, 3'd5, mux_ref(3'd5));
    @(posedge clk); #1;
    start = 1'b1; num_vec = 5'd8;
    for (int t = 1; t <= 2 + 3 * (S + 2); t++) begin
      @(posedge clk); #1;
      if (t == 1) start = 1'b0;
    end
    chk("abort_busy_before", 32'(busy_a), 32'(1));
    chk("abort_stim_before", 32'(stim_a), 32'(3));
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset("abort");
    reset = 1'b0;
    run(8, 1'b0, "rerun");

    // Start and load while busy are ignored; readback run proves vector 2 intact.
    run(8, 1'b1, "disturb");
    run(8, 1'b0, "readback");

    // Five mismatches: saturates the 2-bit counter.
    load_vec(2, 3'd2, ~mux_ref(3'd2));
    load_vec(3, 3'd3, ~mux_ref(3'd3));
    load_vec(4, 3'd4, ~mux_ref(3'd4));
    load_vec(6, 3'd6, ~mux_ref(3'd6));
    load_vec(7, 3'd7, ~mux_ref(3'd7));
    run(8, 1'b0, "sat5");

    // Oversized count is clamped to the full memory.
    for (int a = 0; a < 16; a++) load_vec(a, 3'(a), mux_ref(3'(a)) ^ (a == 11));
    run(20, 1'b0, "clamp");

    // Randomized memory contents, error injection and counts.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 16; a++) begin
        logic [2:0] sv;
        sv = 3'($urandom_range(0, 7));
        load_vec(a, sv, mux_ref(sv) ^ ($urandom_range(0, 3) == 0));
      end
      run(int'($urandom_range(0, 31)), 1'b0, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tv_sequencer.md
TV_SEQUENCER -- requirements
Module: tv_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- STIM_W, 3: stimulus width (mux {d0,d1,sel}).
- RESP_W, 1: DUT response width.
- AW, 4: vector address width; DEPTH = 2**AW.
- SETTLE, 1: wait cycles between apply and sample (>=0).
- ERR_W, 8: error counter width.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- load_en, in, 1: write one vector to memory.
- load_addr, in, AW: vector write address.
- load_data, in, STIM_W+RESP_W: {stimulus, expected}, stimulus in MSBs.
- num_vec, in, AW+1: vector count, sampled on accepted start.
- start, in, 1: begin a run.
- stim, out, STIM_W: registered drive to DUT inputs.
- resp, in, RESP_W: DUT output.
- busy, out, 1: run in progress.
- done, out, 1: run finished; held until next accepted start.
- pass, out, 1: done and err_count==0.
- err_count, out, ERR_W: mismatches, saturating.
- vec_idx, out, AW+1: current vector index.
- first_fail, out, AW+1: index of first mismatch; valid when err_count!=0.

Function
REQ-003 FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
REQ-004 IDLE/DONE with start=1: clear err_count, vec_idx and first_fail, latch num_vec; if num_vec==0 go to DONE, else go to APPLY; done SHALL drop in the same cycle.
REQ-005 APPLY: stim <= stimulus field of mem[vec_idx]; go to WAIT if SETTLE>0, else to CHECK.
REQ-006 WAIT: stay SETTLE cycles (down-counter), then go to CHECK.
REQ-007 CHECK: compare resp with the expected field using 2-state equality; on mismatch increment err_count, saturating at 2**ERR_W-1; on the first mismatch of a run record first_fail=vec_idx.
REQ-008 CHECK: increment vec_idx; if the new value equals the latched num_vec go to DONE, else go to APPLY.
REQ-009 Per-vector latency SHALL be SETTLE+2 cycles; done SHALL rise N*(SETTLE+2)+1 cycles after the start edge for N>0, and 1 cycle after for N=0.
REQ-010 busy SHALL be 1 in APPLY, WAIT and CHECK only; done SHALL be 1 in DONE only; stim SHALL hold its value in every state except APPLY.
REQ-011 start while busy SHALL be ignored.
REQ-012 load_en SHALL write only while busy=0; when busy=1 it is ignored.
REQ-013 num_vec > DEPTH SHALL be clamped to DEPTH when latched.

Reset
REQ-014 reset SHALL force IDLE with stim=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, first_fail=0 and the settle counter at 0, on the next rising edge, from any state including mid-run.
REQ-015 Vector memory contents SHALL NOT be affected by reset.

Structure
REQ-016 A shared package tv_pkg SHALL hold the state enum typedef and the default width constants.
REQ-017 Vector storage SHALL be a sub-module tv_mem: DEPTH x (STIM_W+RESP_W), one synchronous write port, one asynchronous read port addressed by vec_idx.

Verification
REQ-018 Load the 8 correct mux vectors (y = sel ? d1 : d0), num_vec=8, SETTLE=1, start -> done at cycle 25, err_count=0, pass=1, stim sequence 000..111.
REQ-019 Same setup with the expected value of vector 5 inverted -> err_count=1, first_fail=5, pass=0.
REQ-020 num_vec=0, start -> done=1 one cycle later, busy never 1, pass=1.
REQ-021 reset asserted while in WAIT of vector 3 -> next cycle all outputs at reset values; rerun without reloading -> pass=1, showing memory is retained.
REQ-022 start pulse and load_en at address 2 while busy -> no restart; a later readback run shows vector 2 unchanged.
REQ-023 ERR_W=2, 5 mismatching vectors -> err_count=3 (saturated), first_fail set to the first failing index.
